// File: rtl/pyramid_pkg.sv
// rtl/pyramid_pkg.sv - pyramid geometry tables, sequencer state encoding and sizing helpers
package pyramid_pkg;

    localparam int PYR_BASE_WIDTH  = 160;
    localparam int PYR_BASE_HEIGHT = 120;
    localparam int PYR_LEVELS      = 10;
    localparam int PYR_FRAC_BITS   = 16;

    // Level n is (n+1)/LEVELS of the base frame; ratios are (BASE << FRAC_BITS) / dim, floored.
    localparam int PYRAMID_WIDTHS [PYR_LEVELS] = '{16, 32, 48, 64, 80, 96, 112, 128, 144, 160};
    localparam int PYRAMID_HEIGHTS [PYR_LEVELS] = '{12, 24, 36, 48, 60, 72, 84, 96, 108, 120};
    localparam logic [31:0] X_RATIOS [PYR_LEVELS] = '{
        32'd655360, 32'd327680, 32'd218453, 32'd163840, 32'd131072,
        32'd109226, 32'd93622,  32'd81920,  32'd72817,  32'd65536
    };
    localparam logic [31:0] Y_RATIOS [PYR_LEVELS] = '{
        32'd655360, 32'd327680, 32'd218453, 32'd163840, 32'd131072,
        32'd109226, 32'd93622,  32'd81920,  32'd72817,  32'd65536
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_LEVEL_END,
        ST_WAIT_ACK
    } pyr_state_t;

    function automatic int level_dim(input int base, input int lvl, input int levels);
        return base * (lvl + 1) / levels;
    endfunction

    function automatic logic [31:0] level_ratio(input int base, input int dim, input int frac);
        return 32'((longint'(base) << frac) / longint'(dim));
    endfunction

    function automatic int acc_width(input int bw, input int bh, input int frac);
        return frac + $clog2(bw > bh ? bw : bh) + 1;
    endfunction

endpackage

// File: rtl/pyramid_addr_gen.sv
// rtl/pyramid_addr_gen.sv - per-level pixel counters, ratio accumulators and registered address pair
module pyramid_addr_gen #(
    parameter int BASE_WIDTH = 160,
    parameter int FRAC_BITS  = 16,
    parameter int ADDR_W     = 15,
    parameter int ACC_W      = 25
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] ld_width,
    input  logic [ADDR_W-1:0] ld_height,
    input  logic [ACC_W-1:0]  ld_x_ratio,
    input  logic [ACC_W-1:0]  ld_y_ratio,
    input  logic              step,
    output logic [ADDR_W-1:0] src_addr,
    output logic [ADDR_W-1:0] dst_addr,
    output logic              last
);

    logic [ADDR_W-1:0] lvl_width, lvl_height;
    logic [ACC_W-1:0]  x_ratio, y_ratio;
    logic [ADDR_W-1:0] out_x, out_y, src_row, dst_row;
    logic [ACC_W-1:0]  x_acc, y_acc;

    logic [ADDR_W-1:0] nx, ny, nsrc_row, ndst_row;
    logic [ACC_W-1:0]  nx_acc, ny_acc;
    logic              row_end;

    assign row_end = (out_x == lvl_width - ADDR_W'(1));
    assign last    = row_end && (out_y == lvl_height - ADDR_W'(1));

    // Source row base advances by however many base rows the y accumulator crossed.
    always_comb begin
        nx       = out_x + ADDR_W'(1);
        ny       = out_y;
        nx_acc   = x_acc + x_ratio;
        ny_acc   = y_acc;
        nsrc_row = src_row;
        ndst_row = dst_row;
        if (row_end) begin
            nx       = '0;
            nx_acc   = '0;
            ny       = out_y + ADDR_W'(1);
            ny_acc   = y_acc + y_ratio;
            nsrc_row = src_row + ADDR_W'((ny_acc >> FRAC_BITS) - (y_acc >> FRAC_BITS)) * ADDR_W'(BASE_WIDTH);
            ndst_row = dst_row + lvl_width;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lvl_width  <= '0;
            lvl_height <= '0;
            x_ratio    <= '0;
            y_ratio    <= '0;
            out_x      <= '0;
            out_y      <= '0;
            x_acc      <= '0;
            y_acc      <= '0;
            src_row    <= '0;
            dst_row    <= '0;
            src_addr   <= '0;
            dst_addr   <= '0;
        end else if (load) begin
            lvl_width  <= ld_width;
            lvl_height <= ld_height;
            x_ratio    <= ld_x_ratio;
            y_ratio    <= ld_y_ratio;
            out_x      <= '0;
            out_y      <= '0;
            x_acc      <= '0;
            y_acc      <= '0;
            src_row    <= '0;
            dst_row    <= '0;
            src_addr   <= '0;
            dst_addr   <= '0;
        end else if (step) begin
            out_x    <= nx;
            out_y    <= ny;
            x_acc    <= nx_acc;
            y_acc    <= ny_acc;
            src_row  <= nsrc_row;
            dst_row  <= ndst_row;
            src_addr <= nsrc_row + ADDR_W'(nx_acc >> FRAC_BITS);
            dst_addr <= ndst_row + nx;
        end
    end

endmodule

// File: rtl/pyramid_sequencer.sv
// rtl/pyramid_sequencer.sv - walks pyramid levels largest first, handshaking each level with the detector
module pyramid_sequencer
    import pyramid_pkg::*;
#(
    parameter int BASE_WIDTH  = 160,
    parameter int BASE_HEIGHT = 120,
    parameter int LEVELS      = 10,
    parameter int FRAC_BITS   = 16,
    parameter int ADDR_W      = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [ADDR_W-1:0]         src_addr,
    output logic [ADDR_W-1:0]         dst_addr,
    output logic [$clog2(LEVELS)-1:0] level,
    output logic                      level_done,
    input  logic                      level_ack,
    output logic                      frame_done
);

    localparam int LW    = $clog2(LEVELS);
    localparam int ACC_W = acc_width(BASE_WIDTH, BASE_HEIGHT, FRAC_BITS);
    localparam bit USE_PKG_TABLES = (BASE_WIDTH == PYR_BASE_WIDTH) && (BASE_HEIGHT == PYR_BASE_HEIGHT) &&
                                    (LEVELS == PYR_LEVELS) && (FRAC_BITS == PYR_FRAC_BITS);

    logic [ADDR_W-1:0] width_tbl  [LEVELS];
    logic [ADDR_W-1:0] height_tbl [LEVELS];
    logic [ACC_W-1:0]  xr_tbl     [LEVELS];
    logic [ACC_W-1:0]  yr_tbl     [LEVELS];

    // Geometry is constant per level; non-default configurations derive it with the same floor rules.
    for (genvar g = 0; g < LEVELS; g++) begin : g_lvl
        if (USE_PKG_TABLES) begin : g_pkg
            assign width_tbl[g]  = ADDR_W'(PYRAMID_WIDTHS[g]);
            assign height_tbl[g] = ADDR_W'(PYRAMID_HEIGHTS[g]);
            assign xr_tbl[g]     = ACC_W'(X_RATIOS[g]);
            assign yr_tbl[g]     = ACC_W'(Y_RATIOS[g]);
        end else begin : g_calc
            assign width_tbl[g]  = ADDR_W'(level_dim(BASE_WIDTH, g, LEVELS));
            assign height_tbl[g] = ADDR_W'(level_dim(BASE_HEIGHT, g, LEVELS));
            assign xr_tbl[g]     = ACC_W'(level_ratio(BASE_WIDTH, level_dim(BASE_WIDTH, g, LEVELS), FRAC_BITS));
            assign yr_tbl[g]     = ACC_W'(level_ratio(BASE_HEIGHT, level_dim(BASE_HEIGHT, g, LEVELS), FRAC_BITS));
        end
    end

    pyr_state_t    state;
    logic          ack_seen;
    logic          ack_now;
    logic          load;
    logic          step;
    logic          last;
    logic [LW-1:0] load_level;

    assign ack_now    = level_ack || ack_seen;
    assign step       = rd_valid && rd_ready;
    assign load_level = (state == ST_IDLE) ? LW'(LEVELS - 1) : level - LW'(1);
    assign load       = ((state == ST_IDLE) && start) ||
                        ((state == ST_WAIT_ACK) && ack_now && (level != '0));

    pyramid_addr_gen #(
        .BASE_WIDTH (BASE_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ADDR_W     (ADDR_W),
        .ACC_W      (ACC_W)
    ) u_addr_gen (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .ld_width   (width_tbl[load_level]),
        .ld_height  (height_tbl[load_level]),
        .ld_x_ratio (xr_tbl[load_level]),
        .ld_y_ratio (yr_tbl[load_level]),
        .step       (step),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .last       (last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            rd_valid   <= 1'b0;
            level_done <= 1'b0;
            frame_done <= 1'b0;
            ack_seen   <= 1'b0;
            level      <= LW'(LEVELS - 1);
        end else begin
            level_done <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        level    <= LW'(LEVELS - 1);
                        busy     <= 1'b1;
                        rd_valid <= 1'b1;
                        ack_seen <= 1'b0;
                        state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (step && last) begin
                        rd_valid   <= 1'b0;
                        level_done <= 1'b1;
                        state      <= ST_LEVEL_END;
                    end
                end
                ST_LEVEL_END: begin
                    // An early ack is kept so WAIT_ACK can leave without a second one.
                    ack_seen <= level_ack;
                    state    <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (ack_now) begin
                        ack_seen <= 1'b0;
                        if (level != '0) begin
                            level    <= level - LW'(1);
                            rd_valid <= 1'b1;
                            state    <= ST_SCAN;
                        end else begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pyramid_sequencer.sv
// tb/tb_pyramid_sequencer.sv - randomized self-checking bench for pyramid_sequencer on an 8x6, two-level pyramid
module tb_pyramid_sequencer;

    localparam int BW     = 8;
    localparam int BH     = 6;
    localparam int LEVELS = 2;
    localparam int FRAC   = 16;
    localparam int AW     = 8;

    typedef struct {
        int lvl;
        int src;
        int dst;
    } xfer_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          rd_ready = 1'b0;
    logic          level_ack = 1'b0;
    logic          busy, rd_valid, level_done, frame_done;
    logic [AW-1:0] src_addr, dst_addr;
    logic [0:0]    level;

    int    vectors = 0;
    int    miscompares = 0;
    xfer_t exp_q[$];
    xfer_t mon_e;
    int    xfer_cnt = 0;
    int    ld_cnt = 0;
    int    fd_cnt = 0;
    int    ready_mode = 0;
    int    ack_mode = 0;
    int    stall_cnt = 0;
    bit    held = 1'b0;
    logic [AW-1:0] held_src, held_dst;
    logic [0:0]    ack_level;

    pyramid_sequencer #(
        .BASE_WIDTH  (BW),
        .BASE_HEIGHT (BH),
        .LEVELS      (LEVELS),
        .FRAC_BITS   (FRAC),
        .ADDR_W      (AW)
    ) dut (
        .clock      (clk),
        .reset      (rst),
        .start      (start),
        .busy       (busy),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .level      (level),
        .level_done (level_done),
        .level_ack  (level_ack),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Nearest-lower source pixel: coordinate times floored ratio, then drop the fraction.
    task automatic build_frame();
        int lw[LEVELS] = '{4, 8};
        int lh[LEVELS] = '{3, 6};
        exp_q.delete();
        for (int l = LEVELS - 1; l >= 0; l--) begin
            int xr = (BW << FRAC) / lw[l];
            int yr = (BH << FRAC) / lh[l];
            for (int y = 0; y < lh[l]; y++)
                for (int x = 0; x < lw[l]; x++)
                    exp_q.push_back('{lvl: l, src: ((y * yr) >> FRAC) * BW + ((x * xr) >> FRAC), dst: y * lw[l] + x});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 0);
        check({tag, "_level_done"}, 32'(level_done), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_src"}, 32'(src_addr), 0);
        check({tag, "_dst"}, 32'(dst_addr), 0);
        check({tag, "_level"}, 32'(level), LEVELS - 1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (rd_valid && held) begin
                check("hold_src", 32'(src_addr), 32'(held_src));
                check("hold_dst", 32'(dst_addr), 32'(held_dst));
            end
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_xfer", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("xfer_level", 32'(level), mon_e.lvl);
                    check("xfer_src", 32'(src_addr), mon_e.src);
                    check("xfer_dst", 32'(dst_addr), mon_e.dst);
                end
                xfer_cnt++;
                held = 1'b0;
            end else if (rd_valid) begin
                held     = 1'b1;
                held_src = src_addr;
                held_dst = dst_addr;
            end else begin
                held = 1'b0;
            end
            if (level_done) ld_cnt++;
            if (frame_done) fd_cnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) begin
            rd_ready = 1'($urandom_range(0, 1));
        end else if (ready_mode == 2 && xfer_cnt == 3 && stall_cnt < 5) begin
            rd_ready = 1'b0;
            stall_cnt++;
        end else begin
            rd_ready = 1'b1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst && level_done) begin
            ack_level = level;
            if (ack_mode == 2) begin
                level_ack = 1'b1;
                @(posedge clk); #1;
                level_ack = 1'b0;
                @(posedge clk); #1;
                check("auto_resume", (ack_level != 0) ? 32'(rd_valid) : 32'(frame_done), 1);
            end else begin
                if (ack_mode == 1) begin
                    repeat (20) begin
                        @(posedge clk); #1;
                        check("wait_rd_valid", 32'(rd_valid), 0);
                        check("wait_level", 32'(level), 32'(ack_level));
                    end
                end else begin
                    @(posedge clk); #1;
                end
                level_ack = 1'b1;
                @(posedge clk); #1;
                level_ack = 1'b0;
            end
        end
    end

    task automatic run_frame(input int rm, input int am, input bit restart);
        int cyc = 0;
        bit pulsed = 1'b0;
        ready_mode = rm;
        ack_mode   = am;
        stall_cnt  = 0;
        xfer_cnt   = 0;
        ld_cnt     = 0;
        fd_cnt     = 0;
        build_frame();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_rise", 32'(busy), 1);
        check("first_valid", 32'(rd_valid), 1);
        check("first_level", 32'(level), LEVELS - 1);
        while (fd_cnt == 0 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            start = restart && !pulsed && xfer_cnt == 20;
            if (start) pulsed = 1'b1;
        end
        start = 1'b0;
        check("frame_done_seen", fd_cnt, 1);
        check("busy_after", 32'(busy), 0);
        check("frame_done_pulse", 32'(frame_done), 0);
        check("level_done_count", ld_cnt, LEVELS);
        check("xfer_count", xfer_cnt, 60);
        check("exp_left", exp_q.size(), 0);
        if (rm == 2) check("stall_cycles", stall_cnt, 5);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_level();
        int cyc = 0;
        ready_mode = 0;
        ack_mode   = 0;
        xfer_cnt   = 0;
        ld_cnt     = 0;
        fd_cnt     = 0;
        build_frame();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (xfer_cnt < 10 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reset_point", xfer_cnt, 10);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_level_done", ld_cnt, 0);
        check("rst_no_frame_done", fd_cnt, 0);
        check_reset_outputs("held_rst");
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        run_frame(0, 0, 1'b0);
        run_frame(1, 1, 1'b0);
        run_frame(2, 2, 1'b1);
        reset_mid_level();
        run_frame(1, 0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
